uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin merge of three byte sources onto one UART TX
// stream. A channel switch is announced with an ESC,SW_BASE|ch header, and a
// data byte equal to ESC is sent twice so the receiver can tell it apart.
module uart_tx_arbiter #(
  parameter logic [7:0] ESC       = 8'hB1,
  parameter logic [7:0] SW_BASE   = 8'hC0,
  parameter int         MAX_BURST = 16
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       REQ0_VALID_I,
  input  logic [7:0] REQ0_DATA_I,
  input  logic       REQ0_LAST_I,
  output logic       REQ0_READY_O,
  input  logic       REQ1_VALID_I,
  input  logic [7:0] REQ1_DATA_I,
  input  logic       REQ1_LAST_I,
  output logic       REQ1_READY_O,
  input  logic       REQ2_VALID_I,
  input  logic [7:0] REQ2_DATA_I,
  input  logic       REQ2_LAST_I,
  output logic       REQ2_READY_O,
  output logic [7:0] TX_DATA_O,
  output logic       TX_WRITE_O,
  input  logic       TX_READY_I,
  output logic [1:0] CUR_CH_O,
  output logic       BUSY_O
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {IDLE, SW_ESC, SW_SEL, DATA, STUFF} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    r_grant;
  logic [1:0]    r_cur_ch;
  logic [1:0]    r_rr_ptr;
  logic [CW-1:0] r_burst_cnt;
  logic [CW-1:0] w_cnt_inc;

  logic [3:0]    w_valid_vec;
  logic          w_src_valid;
  logic [7:0]    w_src_data;
  logic          w_src_last;
  logic [1:0]    w_c1;
  logic [1:0]    w_c2;
  logic [1:0]    w_c3;
  logic          w_found;
  logic [1:0]    w_pick;
  logic          w_ready;
  logic          w_do_grant;
  logic          w_sel_acc;
  logic          w_consume;
  logic          w_release;

  // Next channel in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  assign w_valid_vec = {1'b0, REQ2_VALID_I, REQ1_VALID_I, REQ0_VALID_I};
  assign w_cnt_inc   = r_burst_cnt + 1'b1;

  // Route the granted source's byte, valid and last flag onto the shared path.
  always_comb begin
    w_src_valid = REQ0_VALID_I;
    w_src_data  = REQ0_DATA_I;
    w_src_last  = REQ0_LAST_I;
    case (r_grant)
      2'd1: begin
        w_src_valid = REQ1_VALID_I;
        w_src_data  = REQ1_DATA_I;
        w_src_last  = REQ1_LAST_I;
      end
      2'd2: begin
        w_src_valid = REQ2_VALID_I;
        w_src_data  = REQ2_DATA_I;
        w_src_last  = REQ2_LAST_I;
      end
      default: ;
    endcase
  end

  // Round-robin search starting at the channel after the last one served.
  always_comb begin
    w_c1    = next_ch(r_rr_ptr);
    w_c2    = next_ch(w_c1);
    w_c3    = next_ch(w_c2);
    w_found = 1'b1;
    w_pick  = w_c1;
    if (w_valid_vec[w_c1]) begin
      w_pick = w_c1;
    end else if (w_valid_vec[w_c2]) begin
      w_pick = w_c2;
    end else if (w_valid_vec[w_c3]) begin
      w_pick = w_c3;
    end else begin
      w_found = 1'b0;
    end
  end

  // Next-state and output decode; the ESC pair and the header are atomic.
  always_comb begin
    w_next_state = r_state;
    TX_DATA_O    = 8'h00;
    TX_WRITE_O   = 1'b0;
    w_ready      = 1'b0;
    w_do_grant   = 1'b0;
    w_sel_acc    = 1'b0;
    w_consume    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_do_grant   = 1'b1;
          w_next_state = (w_pick == r_cur_ch) ? DATA : SW_ESC;
        end
      end
      SW_ESC: begin
        TX_DATA_O  = ESC;
        TX_WRITE_O = 1'b1;
        if (TX_READY_I) w_next_state = SW_SEL;
      end
      SW_SEL: begin
        TX_DATA_O  = SW_BASE | {6'b0, r_grant};
        TX_WRITE_O = 1'b1;
        if (TX_READY_I) begin
          w_sel_acc    = 1'b1;
          w_next_state = DATA;
        end
      end
      DATA: begin
        TX_DATA_O  = w_src_data;
        TX_WRITE_O = w_src_valid;
        if (w_src_data == ESC) begin
          if (w_src_valid && TX_READY_I) w_next_state = STUFF;
        end else begin
          w_ready   = TX_READY_I;
          w_consume = w_src_valid & TX_READY_I;
        end
      end
      STUFF: begin
        TX_DATA_O  = ESC;
        TX_WRITE_O = 1'b1;
        w_ready    = TX_READY_I;
        w_consume  = TX_READY_I;
        if (TX_READY_I) w_next_state = DATA;
      end
      default: w_next_state = IDLE;
    endcase
    if (w_consume && (w_src_last || (w_cnt_inc == CW'(MAX_BURST)))) begin
      w_release    = 1'b1;
      w_next_state = IDLE;
    end
  end

  // State register.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Grant, link channel, round-robin pointer and burst counter.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_grant     <= 2'd0;
      r_cur_ch    <= 2'd0;
      r_rr_ptr    <= 2'd2;
      r_burst_cnt <= '0;
    end else begin
      if (w_do_grant) begin
        r_grant     <= w_pick;
        r_burst_cnt <= '0;
      end else if (w_consume) begin
        r_burst_cnt <= w_cnt_inc;
      end
      if (w_sel_acc) r_cur_ch <= r_grant;
      if (w_release) r_rr_ptr <= r_grant;
    end
  end

  assign REQ0_READY_O = w_ready && (r_grant == 2'd0);
  assign REQ1_READY_O = w_ready && (r_grant == 2'd1);
  assign REQ2_READY_O = w_ready && (r_grant == 2'd2);
  assign CUR_CH_O     = r_cur_ch;
  assign BUSY_O       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-scenario tasks with inline checks.
module tb_uart_tx_arbiter;

  typedef logic [7:0] byte_q_t [$];

  logic       CLK_I;
  logic       RST_NI;
  logic       REQ0_VALID_I, REQ1_VALID_I, REQ2_VALID_I;
  logic [7:0] REQ0_DATA_I, REQ1_DATA_I, REQ2_DATA_I;
  logic       REQ0_LAST_I, REQ1_LAST_I, REQ2_LAST_I;
  logic       REQ0_READY_O, REQ1_READY_O, REQ2_READY_O;
  logic [7:0] TX_DATA_O;
  logic       TX_WRITE_O;
  logic       TX_READY_I;
  logic [1:0] CUR_CH_O;
  logic       BUSY_O;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  byte_q_t    tx_q;
  logic [2:0] hs;
  int         cyc;
  int         pass_cnt;
  int         total_cnt;
  int         rdy0_cycles;
  int         cons0_cnt;
  int         cons0_txpos;
  int         stab_err;
  bit         txr_toggle;
  bit         prev_stall;
  logic [7:0] prev_data;

  uart_tx_arbiter dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI),
    .REQ0_VALID_I(REQ0_VALID_I), .REQ0_DATA_I(REQ0_DATA_I),
    .REQ0_LAST_I(REQ0_LAST_I), .REQ0_READY_O(REQ0_READY_O),
    .REQ1_VALID_I(REQ1_VALID_I), .REQ1_DATA_I(REQ1_DATA_I),
    .REQ1_LAST_I(REQ1_LAST_I), .REQ1_READY_O(REQ1_READY_O),
    .REQ2_VALID_I(REQ2_VALID_I), .REQ2_DATA_I(REQ2_DATA_I),
    .REQ2_LAST_I(REQ2_LAST_I), .REQ2_READY_O(REQ2_READY_O),
    .TX_DATA_O(TX_DATA_O), .TX_WRITE_O(TX_WRITE_O), .TX_READY_I(TX_READY_I),
    .CUR_CH_O(CUR_CH_O), .BUSY_O(BUSY_O)
  );

  // 10-time-unit clock.
  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit same_q(input byte_q_t a, input byte_q_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string q_str(input byte_q_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  // One clock cycle: retire handshaken source bytes, drive inputs on the
  // falling edge, then sample outputs well before the next rising edge.
  task automatic step();
    @(negedge CLK_I);
    if (hs[0] && q0.size() > 0) void'(q0.pop_front());
    if (hs[1] && q1.size() > 0) void'(q1.pop_front());
    if (hs[2] && q2.size() > 0) void'(q2.pop_front());
    cyc++;
    TX_READY_I   = txr_toggle ? cyc[0] : 1'b1;
    REQ0_VALID_I = (q0.size() > 0);
    REQ0_DATA_I  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    REQ0_LAST_I  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
    REQ1_VALID_I = (q1.size() > 0);
    REQ1_DATA_I  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    REQ1_LAST_I  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
    REQ2_VALID_I = (q2.size() > 0);
    REQ2_DATA_I  = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
    REQ2_LAST_I  = (q2.size() > 0) ? q2[0][8]   : 1'b0;
    #2;
    hs = {REQ2_VALID_I & REQ2_READY_O, REQ1_VALID_I & REQ1_READY_O,
          REQ0_VALID_I & REQ0_READY_O};
    if (TX_WRITE_O && TX_READY_I) tx_q.push_back(TX_DATA_O);
    if (prev_stall && TX_WRITE_O && (TX_DATA_O !== prev_data)) stab_err++;
    prev_stall = TX_WRITE_O && !TX_READY_I;
    prev_data  = TX_DATA_O;
    if (REQ0_READY_O) rdy0_cycles++;
    if (hs[0]) begin
      cons0_cnt++;
      cons0_txpos = tx_q.size();
    end
  endtask

  task automatic clear_bench();
    q0.delete();
    q1.delete();
    q2.delete();
    tx_q.delete();
    hs         = 3'b000;
    prev_stall = 1'b0;
    txr_toggle = 1'b0;
  endtask

  task automatic do_reset();
    RST_NI = 1'b0;
    clear_bench();
    step();
    step();
    RST_NI = 1'b1;
  endtask

  // Step until every source queue is empty (and optionally the block idle).
  task automatic drain(input int budget, input bit need_idle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && hs == 3'b000 &&
          (!need_idle || !BUSY_O)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit      ok;
    byte_q_t exp;
    RST_NI = 1'b0;
    clear_bench();
    q0.push_back({1'b1, 8'h55});
    step();
    step();
    total_cnt++;
    if (TX_WRITE_O !== 1'b0) $display("[TB] FAIL reset_txwrite: got %0b want 0", TX_WRITE_O);
    else pass_cnt++;
    total_cnt++;
    if (TX_DATA_O !== 8'h00) $display("[TB] FAIL reset_txdata: got %02h want 00", TX_DATA_O);
    else pass_cnt++;
    total_cnt++;
    if (REQ0_READY_O !== 1'b0) $display("[TB] FAIL reset_ready0: got %0b want 0", REQ0_READY_O);
    else pass_cnt++;
    total_cnt++;
    if (BUSY_O !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", BUSY_O);
    else pass_cnt++;
    total_cnt++;
    if (CUR_CH_O !== 2'd0) $display("[TB] FAIL reset_curch: got %0d want 0", CUR_CH_O);
    else pass_cnt++;
    RST_NI = 1'b1;
    drain(20, 1'b1, ok);
    total_cnt++;
    if (!ok) $display("[TB] FAIL reset_drain: got timeout want drained");
    else pass_cnt++;
    exp = '{8'h55};
    total_cnt++;
    if (!same_q(tx_q, exp)) $display("[TB] FAIL reset_stream: got %s want %s", q_str(tx_q), q_str(exp));
    else pass_cnt++;
    for (int i = 0; i < 3; i++) step();
    total_cnt++;
    if (BUSY_O !== 1'b0 || tx_q.size() != 1)
      $display("[TB] FAIL idle_no_source: got busy=%0b bytes=%0d want busy=0 bytes=1", BUSY_O, tx_q.size());
    else pass_cnt++;
  endtask

  task automatic test_basic();
    bit      ok;
    int      r0;
    byte_q_t exp;
    do_reset();
    r0 = rdy0_cycles;
    q0.push_back({1'b0, 8'h12});
    q0.push_back({1'b1, 8'h34});
    step();
    total_cnt++;
    if (TX_WRITE_O !== 1'b0 || BUSY_O !== 1'b0)
      $display("[TB] FAIL basic_grant_cycle: got write=%0b busy=%0b want 0/0", TX_WRITE_O, BUSY_O);
    else pass_cnt++;
    step();
    total_cnt++;
    if (TX_WRITE_O !== 1'b1 || TX_DATA_O !== 8'h12)
      $display("[TB] FAIL basic_latency: got write=%0b data=%02h want 1/12", TX_WRITE_O, TX_DATA_O);
    else pass_cnt++;
    drain(20, 1'b1, ok);
    total_cnt++;
    if (!ok) $display("[TB] FAIL basic_drain: got timeout want drained");
    else pass_cnt++;
    exp = '{8'h12, 8'h34};
    total_cnt++;
    if (!same_q(tx_q, exp)) $display("[TB] FAIL basic_stream: got %s want %s", q_str(tx_q), q_str(exp));
    else pass_cnt++;
    total_cnt++;
    if (rdy0_cycles - r0 != 2) $display("[TB] FAIL basic_ready_cycles: got %0d want 2", rdy0_cycles - r0);
    else pass_cnt++;
  endtask

  task automatic test_switch();
    bit      ok;
    byte_q_t exp;
    do_reset();
    q1.push_back({1'b1, 8'hAA});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!ok || CUR_CH_O !== 2'd0)
      $display("[TB] FAIL switch_curch_before: got reached=%0b ch=%0d want 1/0", ok, CUR_CH_O);
    else pass_cnt++;
    @(posedge CLK_I);
    #1;
    total_cnt++;
    if (CUR_CH_O !== 2'd1) $display("[TB] FAIL switch_curch_after: got %0d want 1", CUR_CH_O);
    else pass_cnt++;
    drain(20, 1'b1, ok);
    exp = '{8'hB1, 8'hC1, 8'hAA};
    total_cnt++;
    if (!ok || !same_q(tx_q, exp)) $display("[TB] FAIL switch_stream: got %s want %s", q_str(tx_q), q_str(exp));
    else pass_cnt++;
  endtask

  task automatic test_stuff_stall();
    bit      ok;
    int      c0;
    int      s0;
    byte_q_t exp;
    do_reset();
    c0 = cons0_cnt;
    s0 = stab_err;
    txr_toggle = 1'b1;
    q0.push_back({1'b1, 8'hB1});
    drain(40, 1'b1, ok);
    txr_toggle = 1'b0;
    exp = '{8'hB1, 8'hB1};
    total_cnt++;
    if (!ok || !same_q(tx_q, exp)) $display("[TB] FAIL stuff_stream: got %s want %s", q_str(tx_q), q_str(exp));
    else pass_cnt++;
    total_cnt++;
    if (cons0_cnt - c0 != 1) $display("[TB] FAIL stuff_consume_count: got %0d want 1", cons0_cnt - c0);
    else pass_cnt++;
    total_cnt++;
    if (cons0_txpos != 2) $display("[TB] FAIL stuff_consume_pos: got %0d want 2", cons0_txpos);
    else pass_cnt++;
    total_cnt++;
    if (stab_err - s0 != 0) $display("[TB] FAIL stall_stable: got %0d changes want 0", stab_err - s0);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    bit      ok;
    byte_q_t exp;
    do_reset();
    q0.push_back({1'b1, 8'h10});
    q0.push_back({1'b1, 8'h13});
    q1.push_back({1'b1, 8'h21});
    q2.push_back({1'b1, 8'h32});
    drain(80, 1'b1, ok);
    exp = '{8'h10, 8'hB1, 8'hC1, 8'h21, 8'hB1, 8'hC2, 8'h32, 8'hB1, 8'hC0, 8'h13};
    total_cnt++;
    if (!ok || !same_q(tx_q, exp)) $display("[TB] FAIL rr_stream: got %s want %s", q_str(tx_q), q_str(exp));
    else pass_cnt++;
    total_cnt++;
    if (CUR_CH_O !== 2'd0) $display("[TB] FAIL rr_curch: got %0d want 0", CUR_CH_O);
    else pass_cnt++;
  endtask

  task automatic test_burst_limit();
    bit      ok;
    byte_q_t exp;
    do_reset();
    for (int i = 0; i < 20; i++) q2.push_back({1'b0, 8'(8'h40 + i)});
    step();
    step();
    q0.push_back({1'b1, 8'h5A});
    drain(200, 1'b0, ok);
    for (int i = 0; i < 3; i++) step();
    exp = '{8'hB1, 8'hC2};
    for (int i = 0; i < 16; i++) exp.push_back(8'(8'h40 + i));
    exp.push_back(8'hB1);
    exp.push_back(8'hC0);
    exp.push_back(8'h5A);
    exp.push_back(8'hB1);
    exp.push_back(8'hC2);
    for (int i = 16; i < 20; i++) exp.push_back(8'(8'h40 + i));
    total_cnt++;
    if (!ok || !same_q(tx_q, exp)) $display("[TB] FAIL burst_stream: got %s want %s", q_str(tx_q), q_str(exp));
    else pass_cnt++;
    total_cnt++;
    if (BUSY_O !== 1'b1 || TX_WRITE_O !== 1'b0)
      $display("[TB] FAIL burst_hold_grant: got busy=%0b write=%0b want 1/0", BUSY_O, TX_WRITE_O);
    else pass_cnt++;
    total_cnt++;
    if (CUR_CH_O !== 2'd2) $display("[TB] FAIL burst_curch: got %0d want 2", CUR_CH_O);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stuff();
    bit      ok;
    byte_q_t exp;
    do_reset();
    q1.push_back({1'b1, 8'hB1});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_q.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK_I);
    #1;
    total_cnt++;
    if (!ok || TX_WRITE_O !== 1'b1 || TX_DATA_O !== 8'hB1 || CUR_CH_O !== 2'd1)
      $display("[TB] FAIL midstuff_pre: got reached=%0b write=%0b data=%02h ch=%0d want 1/1/b1/1",
               ok, TX_WRITE_O, TX_DATA_O, CUR_CH_O);
    else pass_cnt++;
    RST_NI = 1'b0;
    #1;
    total_cnt++;
    if (TX_WRITE_O !== 1'b0 || CUR_CH_O !== 2'd0 || BUSY_O !== 1'b0)
      $display("[TB] FAIL midstuff_async: got write=%0b ch=%0d busy=%0b want 0/0/0",
               TX_WRITE_O, CUR_CH_O, BUSY_O);
    else pass_cnt++;
    q1.delete();
    step();
    step();
    RST_NI = 1'b1;
    for (int i = 0; i < 5; i++) step();
    exp = '{8'hB1, 8'hC1, 8'hB1};
    total_cnt++;
    if (!same_q(tx_q, exp) || BUSY_O !== 1'b0)
      $display("[TB] FAIL midstuff_abandon: got %s busy=%0b want %s busy=0", q_str(tx_q), BUSY_O, q_str(exp));
    else pass_cnt++;
  endtask

  // Scenario sequence and summary.
  initial begin
    RST_NI       = 1'b0;
    TX_READY_I   = 1'b1;
    REQ0_VALID_I = 1'b0;
    REQ0_DATA_I  = 8'h00;
    REQ0_LAST_I  = 1'b0;
    REQ1_VALID_I = 1'b0;
    REQ1_DATA_I  = 8'h00;
    REQ1_LAST_I  = 1'b0;
    REQ2_VALID_I = 1'b0;
    REQ2_DATA_I  = 8'h00;
    REQ2_LAST_I  = 1'b0;
    cyc          = 0;
    pass_cnt     = 0;
    total_cnt    = 0;
    rdy0_cycles  = 0;
    cons0_cnt    = 0;
    cons0_txpos  = 0;
    stab_err     = 0;
    prev_data    = 8'h00;
    clear_bench();
    test_reset();
    test_basic();
    test_switch();
    test_stuff_stall();
    test_round_robin();
    test_burst_limit();
    test_reset_mid_stuff();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
